// File: rtl/psg_pkg.sv
// Shared types and constants for the PSG wave-table DMA responder.
package psg_pkg;

  localparam int NVOICE   = 4;
  localparam int SAMPLE_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_ACK  = 2'd2
  } psg_state_e;

  function automatic logic [NVOICE-1:0] voice_onehot(input logic [1:0] v);
    logic [NVOICE-1:0] oh;
    oh    = {NVOICE{1'b0}};
    oh[v] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/psg_rr_arbiter.sv
// Combinational round-robin picker: first requesting voice strictly after ptr, wrapping 3->0.
module psg_rr_arbiter
  import psg_pkg::*;
(
  input  logic [NVOICE-1:0] req,
  input  logic [1:0]        ptr,
  output logic [NVOICE-1:0] gnt,
  output logic [1:0]        idx,
  output logic              vld
);

  logic [1:0] cand_s;
  logic       found_s;

  // scan ptr+1 .. ptr+4 (ptr itself last) and keep the first hit
  always_comb begin
    cand_s  = 2'd0;
    found_s = 1'b0;
    idx     = 2'd0;
    for (int i = 1; i <= NVOICE; i++) begin
      cand_s = ptr + 2'(i);
      if (!found_s && req[cand_s]) begin
        found_s = 1'b1;
        idx     = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    vld = found_s;
    if (found_s) begin
      gnt = voice_onehot(idx);
    end else begin
      gnt = {NVOICE{1'b0}};
    end
  end

endmodule

// File: rtl/psg_wave_dma.sv
// Wave-table DMA responder for the 4-voice PSG: round-robin grant, one memory read, one-cycle ack.
// Optional macro PSG_WAVE_DMA_TIMEOUT_EN adds a mem_ack timeout with a sticky err flag.
module psg_wave_dma
  import psg_pkg::*;
#(
  parameter int AW           = 24,
  parameter int DW           = 16,
  parameter int RELEASE_HOLD = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    br,
  input  logic [11:0]   adr0,
  input  logic [11:0]   adr1,
  input  logic [11:0]   adr2,
  input  logic [11:0]   adr3,
  input  logic [AW-1:0] base0,
  input  logic [AW-1:0] base1,
  input  logic [AW-1:0] base2,
  input  logic [AW-1:0] base3,
  output logic [3:0]    bg,
  output logic [2:0]    bgn,
  output logic          ack,
  output logic [11:0]   wave,
  output logic          err,
  output logic          mem_cyc,
  output logic          mem_stb,
  output logic [AW-1:0] mem_adr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_dat_i
);

  localparam int HW = $clog2(RELEASE_HOLD + 1);

  psg_state_e            state_r, state_nx_s;
  logic [1:0]            ptr_r, ptr_nx_s;
  logic [HW-1:0]         hold_r    [NVOICE];
  logic [HW-1:0]         hold_nx_s [NVOICE];
  logic [NVOICE-1:0]     hold_nz_s, elig_s, gnt_s;
  logic [1:0]            gidx_s;
  logic                  gvld_s;
  logic [3:0]            bg_r, bg_nx_s;
  logic [2:0]            bgn_r, bgn_nx_s;
  logic                  ack_r, ack_nx_s;
  logic [SAMPLE_W-1:0]   wave_r, wave_nx_s;
  logic                  cyc_r, cyc_nx_s;
  logic [AW-1:0]         adr_r, adr_nx_s, sum_s;
  logic [11:0]           adr_a_s  [NVOICE];
  logic [AW-1:0]         base_a_s [NVOICE];
  logic                  tmo_hit_s;
  logic                  unused_dat_s;

  assign adr_a_s[0]  = adr0;
  assign adr_a_s[1]  = adr1;
  assign adr_a_s[2]  = adr2;
  assign adr_a_s[3]  = adr3;
  assign base_a_s[0] = base0;
  assign base_a_s[1] = base1;
  assign base_a_s[2] = base2;
  assign base_a_s[3] = base3;
  assign unused_dat_s = ^mem_dat_i[DW-1:SAMPLE_W];

  // eligibility mask for the arbiter
  always_comb begin
    for (int v = 0; v < NVOICE; v++) begin
      hold_nz_s[v] = (hold_r[v] != {HW{1'b0}});
    end
    elig_s = br & ~hold_nz_s & ~bg_r;
  end

  psg_rr_arbiter u_arb (
    .req (elig_s),
    .ptr (ptr_r),
    .gnt (gnt_s),
    .idx (gidx_s),
    .vld (gvld_s)
  );

  // table index is zero-extended; the sum wraps modulo 2^AW
  assign sum_s = base_a_s[gidx_s] + {{(AW-12){1'b0}}, adr_a_s[gidx_s]};

`ifdef PSG_WAVE_DMA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_r;
  logic          err_r;

  assign tmo_hit_s = (state_r == ST_READ) && (tmo_r == TW'(TIMEOUT - 1));
  assign err       = err_r;

  // READ-cycle counter and sticky timeout flag; counter is zero whenever a transfer begins
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_r <= {TW{1'b0}};
      err_r <= 1'b0;
    end else begin
      tmo_r <= (state_r == ST_READ && !mem_ack) ? tmo_r + TW'(1) : {TW{1'b0}};
      err_r <= err_r | (tmo_hit_s && !mem_ack);
    end
  end
`else
  assign tmo_hit_s = 1'b0;
  assign err       = 1'b0;
`endif

  // state register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= 2'd3;
      bg_r    <= 4'd0;
      bgn_r   <= 3'd0;
      ack_r   <= 1'b0;
      wave_r  <= {SAMPLE_W{1'b0}};
      cyc_r   <= 1'b0;
      adr_r   <= {AW{1'b0}};
      for (int v = 0; v < NVOICE; v++) hold_r[v] <= {HW{1'b0}};
    end else begin
      state_r <= state_nx_s;
      ptr_r   <= ptr_nx_s;
      bg_r    <= bg_nx_s;
      bgn_r   <= bgn_nx_s;
      ack_r   <= ack_nx_s;
      wave_r  <= wave_nx_s;
      cyc_r   <= cyc_nx_s;
      adr_r   <= adr_nx_s;
      for (int v = 0; v < NVOICE; v++) hold_r[v] <= hold_nx_s[v];
    end
  end

  // next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (gvld_s) state_nx_s = ST_READ;
        else        state_nx_s = ST_IDLE;
      end
      ST_READ: begin
        if (mem_ack || tmo_hit_s) state_nx_s = ST_ACK;
        else                      state_nx_s = ST_READ;
      end
      ST_ACK:  state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // next values of the registered outputs, pointer and hold counters
  always_comb begin
    ptr_nx_s  = ptr_r;
    bg_nx_s   = bg_r;
    bgn_nx_s  = bgn_r;
    ack_nx_s  = 1'b0;
    wave_nx_s = wave_r;
    cyc_nx_s  = cyc_r;
    adr_nx_s  = adr_r;
    for (int v = 0; v < NVOICE; v++) begin
      if (state_r == ST_ACK && bg_r[v]) begin
        hold_nx_s[v] = HW'(RELEASE_HOLD);
      end else if (hold_nz_s[v]) begin
        hold_nx_s[v] = hold_r[v] - HW'(1);
      end else begin
        hold_nx_s[v] = hold_r[v];
      end
    end
    case (state_r)
      ST_IDLE: begin
        if (gvld_s) begin
          bg_nx_s  = gnt_s;
          bgn_nx_s = {1'b0, gidx_s};
          adr_nx_s = sum_s;
          cyc_nx_s = 1'b1;
          ptr_nx_s = gidx_s;
        end else begin
          cyc_nx_s = 1'b0;
        end
      end
      ST_READ: begin
        if (mem_ack) begin
          wave_nx_s = mem_dat_i[SAMPLE_W-1:0];
          cyc_nx_s  = 1'b0;
          ack_nx_s  = 1'b1;
        end else if (tmo_hit_s) begin
          wave_nx_s = {SAMPLE_W{1'b0}};
          cyc_nx_s  = 1'b0;
          ack_nx_s  = 1'b1;
        end else begin
          cyc_nx_s  = 1'b1;
        end
      end
      ST_ACK: begin
        bg_nx_s = 4'd0;
      end
      default: begin
        bg_nx_s  = 4'd0;
        cyc_nx_s = 1'b0;
      end
    endcase
  end

  assign bg      = bg_r;
  assign bgn     = bgn_r;
  assign ack     = ack_r;
  assign wave    = wave_r;
  assign mem_cyc = cyc_r;
  assign mem_stb = cyc_r;
  assign mem_adr = adr_r;

endmodule

// File: tb/tb_psg_wave_dma.sv
// Directed self-checking bench for psg_wave_dma; memory model returns {4'hF, adr[11:0]^12'hC3C}.
module tb_psg_wave_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  br = 4'd0;
  logic [11:0] adr_t  [4];
  logic [23:0] base_t [4];
  logic [3:0]  bg;
  logic [2:0]  bgn;
  logic        ack, err, mem_cyc, mem_stb;
  logic [11:0] wave;
  logic [23:0] mem_adr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_dat_i = 16'd0;
  logic        mem_en = 1'b0;
  logic        mem_force = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  psg_wave_dma dut (
    .clk(clk), .rst(rst), .br(br),
    .adr0(adr_t[0]), .adr1(adr_t[1]), .adr2(adr_t[2]), .adr3(adr_t[3]),
    .base0(base_t[0]), .base1(base_t[1]), .base2(base_t[2]), .base3(base_t[3]),
    .bg(bg), .bgn(bgn), .ack(ack), .wave(wave), .err(err),
    .mem_cyc(mem_cyc), .mem_stb(mem_stb), .mem_adr(mem_adr),
    .mem_ack(mem_ack), .mem_dat_i(mem_dat_i)
  );

  // zero-wait memory: ack lands in the cycle after stb rises
  always @(posedge clk) begin
    #2;
    mem_ack   = (mem_en && mem_cyc) || mem_force;
    mem_dat_i = {4'hF, mem_adr[11:0] ^ 12'hC3C};
  end

  function automatic logic [11:0] exp_wave(input logic [23:0] a);
    return a[11:0] ^ 12'hC3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    br  = 4'd0;
    tick();
    tick();
    check("rst bg", 32'(bg), 32'h0);
    check("rst bgn", 32'(bgn), 32'h0);
    check("rst ack", 32'(ack), 32'h0);
    check("rst wave", 32'(wave), 32'h0);
    check("rst err", 32'(err), 32'h0);
    check("rst cyc", 32'(mem_cyc), 32'h0);
    check("rst adr", 32'(mem_adr), 32'h0);
    rst = 1'b0;
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (bg == 4'd0 && n < 20) begin
      tick();
      n++;
    end
    check({tag, " grant seen"}, 32'(bg != 4'd0), 32'h1);
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    while (ack == 1'b0 && n < 40) begin
      tick();
      n++;
    end
    check({tag, " ack seen"}, 32'(ack), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  order [5];
    logic [23:0] ea;
    int          early;
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int v = 0; v < 4; v++) begin
      adr_t[v]  = 12'h000;
      base_t[v] = 24'h000000;
    end
    tick();
    do_reset();

    // single request
    base_t[1] = 24'h001000;
    adr_t[1]  = 12'h034;
    br        = 4'b0010;
    mem_en    = 1'b1;
    tick();
    check("t1 bg", 32'(bg), 32'h2);
    check("t1 bgn", 32'(bgn), 32'h1);
    check("t1 mem_adr", 32'(mem_adr), 32'h001034);
    check("t1 stb", 32'(mem_stb), 32'h1);
    check("t1 ack early", 32'(ack), 32'h0);
    br = 4'b0000;
    tick();
    check("t1 ack", 32'(ack), 32'h1);
    check("t1 wave", 32'(wave), 32'hC08);
    check("t1 bgn at ack", 32'(bgn), 32'h1);
    check("t1 cyc dropped", 32'(mem_cyc), 32'h0);
    tick();
    check("t1 ack one cycle", 32'(ack), 32'h0);
    check("t1 bg released", 32'(bg), 32'h0);
    check("t1 wave held", 32'(wave), 32'hC08);

    // contention, pointer starts at 3
    do_reset();
    base_t[0] = 24'h000000; adr_t[0] = 12'h011;
    base_t[1] = 24'h000100; adr_t[1] = 12'h022;
    base_t[2] = 24'h000200; adr_t[2] = 12'h033;
    base_t[3] = 24'h000300; adr_t[3] = 12'h044;
    br = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      ea = base_t[order[k]] + {12'h000, adr_t[order[k]]};
      wait_grant("t2");
      check("t2 bg order", 32'(bg), 32'(4'b0001 << order[k]));
      check("t2 bgn order", 32'(bgn), 32'(order[k]));
      check("t2 mem_adr", 32'(mem_adr), 32'(ea));
      wait_ack("t2");
      check("t2 wave", 32'(wave), 32'(exp_wave(ea)));
      tick();
      check("t2 single ack", 32'(ack), 32'h0);
    end
    br = 4'b0000;
    tick();
    tick();

    // hold-off after release
    br = 4'b0100;
    wait_grant("t3");
    check("t3 bg", 32'(bg), 32'h4);
    wait_ack("t3");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3 no regrant", 32'(bg), 32'h0);
    end
    tick();
    check("t3 regrant", 32'(bg), 32'h4);
    br = 4'b0000;
    wait_ack("t3 second");
    tick();
    tick();

    // reset in the middle of READ
    mem_en = 1'b0;
    br     = 4'b1000;
    wait_grant("t4");
    check("t4 bg", 32'(bg), 32'h8);
    br = 4'b0000;
    tick();
    check("t4 cyc held", 32'(mem_cyc), 32'h1);
    rst = 1'b1;
    tick();
    check("t4 cyc abort", 32'(mem_cyc), 32'h0);
    check("t4 bg abort", 32'(bg), 32'h0);
    check("t4 ack abort", 32'(ack), 32'h0);
    rst       = 1'b0;
    mem_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4 late ack ignored", 32'(ack), 32'h0);
      check("t4 wave after abort", 32'(wave), 32'h0);
    end
    mem_force = 1'b0;
    tick();

    // address wrap
    base_t[0] = 24'hFFFFFF;
    adr_t[0]  = 12'h002;
    mem_en    = 1'b1;
    br        = 4'b0001;
    wait_grant("t5");
    check("t5 bgn", 32'(bgn), 32'h0);
    check("t5 mem_adr wrap", 32'(mem_adr), 32'h000001);
    br = 4'b0000;
    wait_ack("t5");
    check("t5 wave", 32'(wave), 32'hC3D);
    tick();

`ifdef PSG_WAVE_DMA_TIMEOUT_EN
    // memory never answers
    mem_en = 1'b0;
    br     = 4'b0010;
    wait_grant("t6");
    br    = 4'b0000;
    early = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (ack) early++;
    end
    check("t6 no early ack", 32'(early), 32'h0);
    tick();
    check("t6 ack", 32'(ack), 32'h1);
    check("t6 wave zero", 32'(wave), 32'h0);
    check("t6 err", 32'(err), 32'h1);
    tick();
    tick();
    check("t6 err sticky", 32'(err), 32'h1);
    do_reset();
`else
    check("err tied low", 32'(err), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
